// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage sitting directly in front of the ALU stage. Owns the
// program counter, reads a synchronous instruction memory with one cycle of
// read latency, resolves JMP and HALT locally and squashes the single
// wrong-path instruction on a taken BRZ reported by the ALU.
//
// Ports
//   clk         in   1       single clock, all state updates on posedge
//   rst         in   1       asynchronous, active-high reset
//   run         in   1       fetch enable; 0 pauses issue and holds the PC
//   imem_addr   out  ADDR_W  instruction memory read address
//   imem_rd_en  out  1       read strobe; data appears on imem_data next cycle
//   imem_data   in   16      instruction for the previous cycle's read
//   ins_out     out  16      instruction to the ALU; 16'h0000 (NOP) if none
//   branch_en   in   1       taken BRZ from the ALU (same-cycle)
//   branch_val  in   16      BRZ target; only [ADDR_W-1:0] used
//   halted      out  1       HALT retired; sticky until rst
//   dbg_state   out  1       current FSM state (0 = FETCH, 1 = HALTED)
//
// Handshake: there is no backpressure. A read issued with imem_rd_en in cycle
// t is always consumed in cycle t+1 (delivered, redirected or squashed), and
// ins_out is accepted by the ALU every cycle.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [3:0]         OP_JMP   = 4'h6,
  parameter logic [3:0]         OP_HALT  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [15:0]       imem_data,
  output logic [15:0]       ins_out,
  input  logic              branch_en,
  input  logic [15:0]       branch_val,
  output logic              halted,
  output logic              dbg_state
);

  typedef enum logic [0:0] {
    S_FETCH  = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              vld_q, vld_d;

  logic [3:0] op;
  logic       br_act;
  logic       jmp_hit;
  logic       halt_hit;

  assign op = imem_data[15:12];

  // A taken branch only matters while fetching; once halted it is ignored.
  assign br_act   = branch_en & (state_q == S_FETCH);
  // JMP/HALT arriving alongside a taken branch are wrong-path and discarded.
  assign jmp_hit  = vld_q & (op == OP_JMP)  & ~br_act;
  assign halt_hit = vld_q & (op == OP_HALT) & ~br_act;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    vld_d      = 1'b0;
    imem_addr  = pc_q;
    imem_rd_en = 1'b0;
    ins_out    = 16'h0000;

    // Redirect priority: ALU branch, then local JMP, then sequential PC.
    if (br_act) begin
      imem_addr = branch_val[ADDR_W-1:0];
    end else if (jmp_hit) begin
      imem_addr = imem_data[ADDR_W-1:0];
    end

    // Reset also gates the strobe so no read is issued while it is held.
    imem_rd_en = ~rst & run & (state_q == S_FETCH) & ~halt_hit;

    if (vld_q & ~br_act & ~jmp_hit & ~halt_hit) begin
      ins_out = imem_data;
    end

    if (imem_rd_en) begin
      pc_d  = imem_addr + ADDR_W'(1);
      vld_d = 1'b1;
    end else if (br_act | jmp_hit) begin
      // Paused fetch still records the redirect so it resumes at the target.
      pc_d = imem_addr;
    end

    if ((state_q == S_FETCH) && halt_hit) begin
      state_d = S_HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
    end
  end

  assign halted    = (state_q == S_HALTED);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A behavioural 4K x 16 synchronous memory
// answers the fetch reads. Each observation packs
// {halted, imem_rd_en, imem_addr, ins_out} into 30 bits and is compared with a
// hand-computed value; msk blanks fields the design leaves undefined.
// Default memory contents are {4'h2, addr}, so mem[k] = 16'h2000 + k.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        run;
  logic [11:0] imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_data;
  logic [15:0] ins_out;
  logic        branch_en;
  logic [15:0] branch_val;
  logic        halted;
  logic        dbg_state;

  logic [15:0] mem [0:4095];
  logic [29:0] obs;
  logic [29:0] exp_v;
  logic [29:0] msk;
  int          n_tests;
  int          n_fail;

  localparam logic [29:0] MSK_ALL  = 30'h3FFF_FFFF;
  localparam logic [29:0] MSK_NOAD = {2'b11, 12'h000, 16'hFFFF};

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_addr  (imem_addr),
    .imem_rd_en (imem_rd_en),
    .imem_data  (imem_data),
    .ins_out    (ins_out),
    .branch_en  (branch_en),
    .branch_val (branch_val),
    .halted     (halted),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous instruction memory, one cycle read latency
  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= mem[imem_addr];
  end

  always_comb obs = {halted, imem_rd_en, imem_addr, ins_out};

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic init_mem();
    for (int i = 0; i < 4096; i++) mem[i] = {4'h2, 12'(i)};
  endtask

  // Leaves the bench in cycle c0: reset just released, first read pending.
  task automatic do_reset();
    rst        = 1'b1;
    run        = 1'b1;
    branch_en  = 1'b0;
    branch_val = 16'h0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  // Advance one cycle; branch_en is always a single-cycle pulse.
  task automatic step();
    @(posedge clk);
    #1;
    branch_en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    init_mem();
    rst = 1'b1; run = 1'b1; branch_en = 1'b0; branch_val = 16'h0000;
    @(posedge clk); #1;
    exp_v = {1'b0, 1'b0, 12'h000, 16'h0000}; msk = MSK_ALL;
    n_tests++; if ((obs & msk) !== exp_v) begin n_fail++; $display("FAIL reset_state got %h exp %h", obs, exp_v); end
    n_tests++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_dbg_state got %b exp 0", dbg_state); end
  endtask

  task automatic test_sequential();
    init_mem();
    mem[0] = 16'h1000; mem[1] = 16'h3000; mem[2] = 16'h8000;
    do_reset();
    msk = MSK_ALL;
    exp_v = {1'b0, 1'b1, 12'h000, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL seq_c0 got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'h001, 16'h1000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL seq_c1 got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'h002, 16'h3000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL seq_c2 got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'h003, 16'h8000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL seq_c3 got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_jmp();
    init_mem();
    mem[2] = 16'h6005;
    do_reset();
    step(); step(); step();
    exp_v = {1'b0, 1'b1, 12'h005, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL jmp_slot got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'h006, 16'h2005};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL jmp_target got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_branch();
    init_mem();
    do_reset();
    step(); step(); step(); step();
    branch_en = 1'b1; branch_val = 16'h0010; #1;
    exp_v = {1'b0, 1'b1, 12'h010, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL brz_squash got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'h011, 16'h2010};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL brz_target got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_halt();
    init_mem();
    mem[4] = 16'hF000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      exp_v = {1'b0, 1'b1, 12'(i + 1), 4'h2, 12'(i)};
      n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL halt_pre%0d got %h exp %h", i, obs, exp_v); end
    end
    step(); exp_v = {1'b0, 1'b0, 12'h005, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL halt_slot got %h exp %h", obs, exp_v); end
    msk = MSK_NOAD;
    step(); exp_v = {1'b1, 1'b0, 12'h000, 16'h0000};
    n_tests++; if ((obs & msk) !== exp_v) begin n_fail++; $display("FAIL halt_after got %h exp %h", obs & msk, exp_v); end
    n_tests++; if (dbg_state !== 1'b1) begin n_fail++; $display("FAIL halt_dbg_state got %b exp 1", dbg_state); end
    step(); branch_en = 1'b1; branch_val = 16'h0020; #1;
    n_tests++; if ((obs & msk) !== exp_v) begin n_fail++; $display("FAIL halt_ign_brz got %h exp %h", obs & msk, exp_v); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if ((obs & msk) !== exp_v) begin n_fail++; $display("FAIL halt_sticky%0d got %h exp %h", i, obs & msk, exp_v); end
    end
    msk = MSK_ALL;
  endtask

  task automatic test_branch_vs_halt();
    init_mem();
    mem[4] = 16'hF000;
    do_reset();
    step(); step(); step(); step(); step();
    branch_en = 1'b1; branch_val = 16'h0020; #1;
    exp_v = {1'b0, 1'b1, 12'h020, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL brz_halt_slot got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'h021, 16'h2020};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL brz_halt_target got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'h022, 16'h2021};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL brz_halt_cont got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_branch_vs_jmp();
    init_mem();
    mem[2] = 16'h6005;
    do_reset();
    step(); step(); step();
    branch_en = 1'b1; branch_val = 16'h0020; #1;
    exp_v = {1'b0, 1'b1, 12'h020, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL brz_jmp_slot got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'h021, 16'h2020};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL brz_jmp_target got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_run_pause();
    init_mem();
    mem[0] = 16'h6005;
    do_reset();
    step(); run = 1'b0; #1;
    exp_v = {1'b0, 1'b0, 12'h005, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL run0_jmp got %h exp %h", obs, exp_v); end
    step();
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL run0_hold got %h exp %h", obs, exp_v); end
    branch_en = 1'b1; branch_val = 16'h0010; #1;
    exp_v = {1'b0, 1'b0, 12'h010, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL run0_brz got %h exp %h", obs, exp_v); end
    step();
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL run0_brz_pc got %h exp %h", obs, exp_v); end
    run = 1'b1; #1;
    exp_v = {1'b0, 1'b1, 12'h010, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL run1_resume got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'h011, 16'h2010};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL run1_data got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_mid_reset();
    init_mem();
    do_reset();
    step(); step();
    rst = 1'b1; #1;
    exp_v = {1'b0, 1'b0, 12'h000, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL midrst_async got %h exp %h", obs, exp_v); end
    @(posedge clk); #1; rst = 1'b0; #1;
    exp_v = {1'b0, 1'b1, 12'h000, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL midrst_release got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'h001, 16'h2000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL midrst_restart got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_wrap();
    init_mem();
    mem[0] = 16'h6FFF; mem[12'hFFF] = 16'hABCD;
    do_reset();
    step(); exp_v = {1'b0, 1'b1, 12'hFFF, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_jmp got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'h000, 16'hABCD};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_pc got %h exp %h", obs, exp_v); end
    step(); exp_v = {1'b0, 1'b1, 12'hFFF, 16'h0000};
    n_tests++; if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_again got %h exp %h", obs, exp_v); end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    msk        = MSK_ALL;
    rst        = 1'b1;
    run        = 1'b0;
    branch_en  = 1'b0;
    branch_val = 16'h0000;
    imem_data  = 16'h0000;
    test_reset();
    test_sequential();
    test_jmp();
    test_branch();
    test_halt();
    test_branch_vs_halt();
    test_branch_vs_jmp();
    test_run_pause();
    test_mid_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
